alu_op_sequencer: RTL

Multi-cycle execution controller for the processor's integer ALU operations. It accepts a decoded 3-bit ALU operation code plus two operands through a valid/ready handshake. Logical, add and subtract operations complete in one cycle; multiply (shift-add) and divide (restoring) are sequenced over WIDTH iterations. It sits between the ALU control decoder and the writeback path, and its `busy` output stalls instruction issue while an iterative operation is in flight.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_seq_divider.sv | 44 ++++
 rtl/alu_op_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared op codes and FSM state type for the ALU operation sequencer.
// The ALU control decoder uses the same ALUOP_* constants.
package alu_seq_pkg;

    localparam logic [2:0] ALUOP_NOP = 3'b000;
    localparam logic [2:0] ALUOP_ADD = 3'b001;
    localparam logic [2:0] ALUOP_SUB = 3'b010;
    localparam logic [2:0] ALUOP_MUL = 3'b011;
    localparam logic [2:0] ALUOP_DIV = 3'b100;
    localparam logic [2:0] ALUOP_AND = 3'b101;
    localparam logic [2:0] ALUOP_OR  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_seq_divider.sv
// Unsigned restoring divider step register: one quotient bit per step, MSB first.
// quotient_next is the quotient as it will stand after the current step.
module alu_seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient_next
);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             ge;

    // One extra bit on the shifted remainder keeps the trial subtraction exact;
    // its sign bit doubles as the restore decision.
    assign rem_sh        = {rem, quo[WIDTH-1]};
    assign diff          = rem_sh - {1'b0, dvs};
    assign ge            = ~diff[WIDTH];
    assign quotient_next = {quo[WIDTH-2:0], ge};

    always_ff @(posedge clk) begin
        if (reset) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
        end else if (step) begin
            rem <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo <= quotient_next;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU execution controller: single-cycle simple ops, shift-add mul,
// restoring div. Divider present only when ALU_SEQ_DIV_EN is defined.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       aluop,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             div_by_zero,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Handshake: a request is accepted on any rising edge where start_valid && start_ready;
    // start_ready is high only in IDLE and the requester holds its request until accepted.
    localparam int CW = $clog2(WIDTH) + 1;
`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    alu_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mul_sum;
    logic [WIDTH-1:0] simple_result;
    logic             dbz_q;
    logic             accept;

    assign accept      = start_valid && start_ready;
    assign mul_sum     = acc + (mplier[0] ? mcand : '0);
    assign div_by_zero = DIV_EN ? dbz_q : 1'b0;
    assign state_dbg   = state;

    always_comb begin
        simple_result = '0;
        case (aluop)
            ALUOP_ADD: simple_result = operand_a + operand_b;
            ALUOP_SUB: simple_result = operand_a - operand_b;
            ALUOP_AND: simple_result = operand_a & operand_b;
            ALUOP_OR:  simple_result = operand_a | operand_b;
            default:   simple_result = '0;
        endcase
    end

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0] div_q_next;
    logic             div_load;

    assign div_load = accept && (aluop == ALUOP_DIV) && (operand_b != '0);

    alu_seq_divider #(.WIDTH(WIDTH)) u_divider (
        .clk           (clk),
        .reset         (reset),
        .load          (div_load),
        .step          (state == ST_DIV),
        .dividend      (operand_a),
        .divisor       (operand_b),
        .quotient_next (div_q_next)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            result       <= '0;
            result_valid <= 1'b0;
            dbz_q        <= 1'b0;
            busy         <= 1'b0;
            start_ready  <= 1'b1;
            cnt          <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        busy        <= 1'b1;
                        start_ready <= 1'b0;
                        case (aluop)
                            ALUOP_MUL: begin
                                acc    <= '0;
                                mcand  <= operand_a;
                                mplier <= operand_b;
                                cnt    <= CW'(WIDTH);
                                state  <= ST_MUL;
                            end
`ifdef ALU_SEQ_DIV_EN
                            ALUOP_DIV: begin
                                if (operand_b == '0) begin
                                    result       <= '1;
                                    dbz_q        <= 1'b1;
                                    result_valid <= 1'b1;
                                    state        <= ST_DONE;
                                end else begin
                                    cnt   <= CW'(WIDTH);
                                    state <= ST_DIV;
                                end
                            end
`endif
                            default: begin
                                result       <= simple_result;
                                dbz_q        <= 1'b0;
                                result_valid <= 1'b1;
                                state        <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result       <= mul_sum;
                        dbz_q        <= 1'b0;
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                ST_DIV: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result       <= div_q_next;
                        dbz_q        <= 1'b0;
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
`endif
                default: begin
                    // DONE (and an unreachable DIV when the divider is absent) returns to IDLE.
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
